// File: rtl/lbuff_sched_if.sv
// Bundle between the VGA timing / line buffer pair and lbuff_sched.
// The master side drives the strobes and fill-done pulses; the slave side is the scheduler.
interface lbuff_sched_if #(
   parameter int LBUFF_ADDR_WIDTH = 8,
   parameter int ROW_WIDTH        = 7
);
   logic                        frame_start_i;
   logic                        line_start_i;
   logic                        pxl_en_i;
   logic [1:0]                  buff_fill_done_i;
   logic [1:0]                  buff_fill_req_o;
   logic [1:0]                  buff_sel_o;
   logic [LBUFF_ADDR_WIDTH-1:0] disp_pxl_id_o;
   logic [ROW_WIDTH-1:0]        fill_row_o;
   logic                        underrun_o;
   logic [7:0]                  underrun_cnt_o;

   modport master (
      output frame_start_i, line_start_i, pxl_en_i, buff_fill_done_i,
      input  buff_fill_req_o, buff_sel_o, disp_pxl_id_o, fill_row_o,
             underrun_o, underrun_cnt_o
   );

   modport slave (
      input  frame_start_i, line_start_i, pxl_en_i, buff_fill_done_i,
      output buff_fill_req_o, buff_sel_o, disp_pxl_id_o, fill_row_o,
             underrun_o, underrun_cnt_o
   );
endinterface

// File: rtl/lbuff_sched.sv
// Ping-pong line buffer scheduler: primes both buffers, swaps display every TILE_HEIGHT lines,
// requests fills one tile row ahead and generates the tile read index. Option: LBUFF_SCHED_STATS_EN.
module lbuff_sched #(
   parameter int WIDTH_PX         = 640,
   parameter int HEIGHT_PX        = 480,
   parameter int TILE_WIDTH       = 4,
   parameter int TILE_HEIGHT      = 4,
   parameter int TILE_PER_LINE    = WIDTH_PX / TILE_WIDTH,
   parameter int TILE_ROWS        = HEIGHT_PX / TILE_HEIGHT,
   parameter int LBUFF_ADDR_WIDTH = $clog2(TILE_PER_LINE),
   parameter int ROW_WIDTH        = $clog2(TILE_ROWS)
) (
   input  logic         clk_i,
   input  logic         rst_i,
   lbuff_sched_if.slave bus
);
   localparam int SUB_W = (TILE_WIDTH > 1) ? $clog2(TILE_WIDTH) : 1;
   localparam int LC_W  = (TILE_HEIGHT > 1) ? $clog2(TILE_HEIGHT) : 1;

   localparam logic [SUB_W-1:0]            SUB_MAX = SUB_W'(TILE_WIDTH - 1);
   localparam logic [LC_W-1:0]             LC_MAX  = LC_W'(TILE_HEIGHT - 1);
   localparam logic [LBUFF_ADDR_WIDTH-1:0] ID_MAX  = LBUFF_ADDR_WIDTH'(TILE_PER_LINE - 1);
   localparam logic [ROW_WIDTH-1:0]        ROW_MAX = ROW_WIDTH'(TILE_ROWS - 1);
   localparam logic [ROW_WIDTH:0]          ROW_END = (ROW_WIDTH + 1)'(TILE_ROWS);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_PRIME0  = 3'd1;
   localparam logic [2:0] ST_PRIME1  = 3'd2;
   localparam logic [2:0] ST_DISPLAY = 3'd3;
   localparam logic [2:0] ST_DRAIN   = 3'd4;

   logic [2:0]                  state;
   logic [1:0]                  pending;
   logic [1:0]                  full;
   logic                        req_due;
   logic                        req_buf;
   logic                        first_line;
   logic [LC_W-1:0]             line_cnt;
   logic [ROW_WIDTH-1:0]        disp_row;
   logic [ROW_WIDTH:0]          next_row;
   logic [1:0]                  fill_req;
   logic [1:0]                  sel;
   logic [ROW_WIDTH-1:0]        fill_row;
   logic                        underrun;
   logic [SUB_W-1:0]            sub_cnt;
   logic [LBUFF_ADDR_WIDTH-1:0] pxl_id;

   logic [1:0] done_hit;
   logic       line_ev;
   logic       last_line;
   logic       swap_ev;
   logic       rel_idx;
   logic       tgt_idx;
   logic       underrun_ev;

   // Done pulses for buffers without an outstanding fill are dropped here.
   assign done_hit    = bus.buff_fill_done_i & pending;
   assign line_ev     = (state == ST_DISPLAY) && bus.line_start_i && !bus.frame_start_i;
   assign last_line   = !first_line && (line_cnt == LC_MAX);
   assign swap_ev     = line_ev && last_line && (disp_row != ROW_MAX);
   assign rel_idx     = sel[1];
   assign tgt_idx     = sel[0];
   assign underrun_ev = swap_ev && !(full[tgt_idx] || done_hit[tgt_idx]);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= ST_IDLE;
         pending    <= '0;
         full       <= '0;
         req_due    <= 1'b0;
         req_buf    <= 1'b0;
         first_line <= 1'b0;
         line_cnt   <= '0;
         disp_row   <= '0;
         next_row   <= '0;
         fill_req   <= '0;
         sel        <= '0;
         fill_row   <= '0;
         underrun   <= 1'b0;
      end else begin
         fill_req <= '0;
         pending  <= pending & ~done_hit;
         full     <= full | done_hit;
         if (bus.frame_start_i) begin
            // Start or abort: an in-flight fill must land before priming restarts.
            underrun   <= 1'b0;
            sel        <= '0;
            full       <= '0;
            req_due    <= 1'b0;
            first_line <= 1'b1;
            line_cnt   <= '0;
            disp_row   <= '0;
            next_row   <= '0;
            state      <= ((pending & ~done_hit) != '0) ? ST_DRAIN : ST_PRIME0;
         end else begin
            case (state)
               ST_IDLE: ;
               ST_DRAIN: begin
                  if ((pending & ~done_hit) == '0) state <= ST_PRIME0;
               end
               ST_PRIME0: begin
                  if (done_hit[0]) begin
                     state <= ST_PRIME1;
                  end else if (pending == '0) begin
                     fill_req <= 2'b01;
                     pending  <= 2'b01;
                     fill_row <= '0;
                     next_row <= (ROW_WIDTH + 1)'(1);
                  end
               end
               ST_PRIME1: begin
                  if (pending == '0) begin
                     fill_req <= 2'b10;
                     pending  <= 2'b10;
                     fill_row <= ROW_WIDTH'(1);
                     next_row <= (ROW_WIDTH + 1)'(2);
                     state    <= ST_DISPLAY;
                  end
               end
               ST_DISPLAY: begin
                  if (req_due && (pending == '0)) begin
                     fill_req <= {req_buf, ~req_buf};
                     pending  <= {req_buf, ~req_buf};
                     fill_row <= next_row[ROW_WIDTH-1:0];
                     next_row <= next_row + 1'b1;
                     req_due  <= 1'b0;
                  end
                  if (line_ev) begin
                     if (first_line) begin
                        sel        <= 2'b01;
                        line_cnt   <= '0;
                        first_line <= 1'b0;
                     end else if (!last_line) begin
                        line_cnt <= line_cnt + 1'b1;
                     end else if (!swap_ev) begin
                        sel   <= '0;
                        state <= ST_IDLE;
                     end else begin
                        line_cnt      <= '0;
                        disp_row      <= disp_row + 1'b1;
                        sel           <= {sel[0], sel[1]};
                        full[rel_idx] <= 1'b0;
                        if (underrun_ev) underrun <= 1'b1;
                        if (next_row < ROW_END) begin
                           req_due <= 1'b1;
                           req_buf <= rel_idx;
                        end
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   // Tile index runs off the pixel strobe regardless of scheduler state.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sub_cnt <= '0;
         pxl_id  <= '0;
      end else if (bus.line_start_i) begin
         sub_cnt <= '0;
         pxl_id  <= '0;
      end else if (bus.pxl_en_i) begin
         if (sub_cnt == SUB_MAX) begin
            sub_cnt <= '0;
            pxl_id  <= (pxl_id == ID_MAX) ? '0 : pxl_id + 1'b1;
         end else begin
            sub_cnt <= sub_cnt + 1'b1;
         end
      end
   end

`ifdef LBUFF_SCHED_STATS_EN
   logic [7:0] urun_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         urun_cnt <= '0;
      end else if (underrun_ev && (urun_cnt != '1)) begin
         urun_cnt <= urun_cnt + 1'b1;
      end
   end

   assign bus.underrun_cnt_o = urun_cnt;
`else
   assign bus.underrun_cnt_o = '0;
`endif

   assign bus.buff_fill_req_o = fill_req;
   assign bus.buff_sel_o      = sel;
   assign bus.disp_pxl_id_o   = pxl_id;
   assign bus.fill_row_o      = fill_row;
   assign bus.underrun_o      = underrun;
endmodule

// File: tb/tb_lbuff_sched.sv
// Directed bench for lbuff_sched with a 100-cycle line buffer fill responder.
module tb_lbuff_sched;
   localparam int FILL_CYCLES = 100;
   localparam int LINE_GAP    = 40;
`ifdef LBUFF_SCHED_STATS_EN
   localparam int EXP_UCNT = 1;
`else
   localparam int EXP_UCNT = 0;
`endif

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   int         checks    = 0;
   int         failures  = 0;
   int         req_count = 0;
   int         proto_err = 0;
   logic [1:0] last_req  = '0;
   logic [6:0] last_row  = '0;
   logic [1:0] hold_done = '0;

   lbuff_sched_if bus ();

   lbuff_sched dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   // Downstream line buffer: one fill at a time, done FILL_CYCLES later unless held.
   initial begin : responder
      logic       busy;
      logic [1:0] busy_buf;
      logic [1:0] prev_req;
      int         wait_cnt;
      busy = 1'b0;
      busy_buf = '0;
      prev_req = '0;
      wait_cnt = 0;
      bus.buff_fill_done_i = '0;
      forever begin
         @(negedge clk_i);
         bus.buff_fill_done_i = '0;
         if (rst_i) begin
            busy = 1'b0;
            prev_req = '0;
         end else begin
            if (bus.buff_fill_req_o != '0) begin
               req_count++;
               last_req = bus.buff_fill_req_o;
               last_row = bus.fill_row_o;
               if (!$onehot(bus.buff_fill_req_o)) proto_err++;
               if (prev_req != '0) proto_err++;
               if (busy) proto_err++;
               if ((bus.buff_fill_req_o & bus.buff_sel_o) != '0) proto_err++;
               busy = 1'b1;
               busy_buf = bus.buff_fill_req_o;
               wait_cnt = FILL_CYCLES;
            end else if (busy) begin
               if (wait_cnt > 0) wait_cnt--;
               if (wait_cnt == 0 && (busy_buf & hold_done) == '0) begin
                  bus.buff_fill_done_i = busy_buf;
                  busy = 1'b0;
               end
            end
            prev_req = bus.buff_fill_req_o;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic line_pulse();
      bus.line_start_i = 1'b1;
      @(negedge clk_i);
      bus.line_start_i = 1'b0;
   endtask

   task automatic frame_pulse();
      bus.frame_start_i = 1'b1;
      @(negedge clk_i);
      bus.frame_start_i = 1'b0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      hold_done = '0;
      tick(3);
      rst_i = 1'b0;
      tick(2);
   endtask

   task automatic wait_req(input int budget, output logic [1:0] req, output logic [6:0] row,
                           output bit seen);
      seen = 1'b0;
      req  = '0;
      row  = '0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk_i);
         if (bus.buff_fill_req_o != '0) begin
            seen = 1'b1;
            req  = bus.buff_fill_req_o;
            row  = bus.fill_row_o;
         end
      end
   endtask

   task automatic test_reset();
      int base;
      rst_i = 1'b1;
      tick(2);
      checks++; if (bus.buff_fill_req_o !== 2'b00) begin failures++; $display("FAIL rst_req got=%b exp=00", bus.buff_fill_req_o); end
      checks++; if (bus.buff_sel_o !== 2'b00) begin failures++; $display("FAIL rst_sel got=%b exp=00", bus.buff_sel_o); end
      checks++; if (bus.disp_pxl_id_o !== 8'd0) begin failures++; $display("FAIL rst_id got=%0d exp=0", bus.disp_pxl_id_o); end
      checks++; if (bus.fill_row_o !== 7'd0) begin failures++; $display("FAIL rst_row got=%0d exp=0", bus.fill_row_o); end
      checks++; if (bus.underrun_o !== 1'b0) begin failures++; $display("FAIL rst_underrun got=%b exp=0", bus.underrun_o); end
      checks++; if (bus.underrun_cnt_o !== 8'd0) begin failures++; $display("FAIL rst_ucnt got=%0d exp=0", bus.underrun_cnt_o); end
      base = req_count;
      rst_i = 1'b0;
      tick(30);
      checks++; if (req_count - base !== 0) begin failures++; $display("FAIL rst_no_req got=%0d exp=0", req_count - base); end
   endtask

   task automatic test_pixel_index();
      line_pulse();
      for (int k = 0; k < 640; k++) begin
         checks++;
         if (bus.disp_pxl_id_o !== 8'(k / 4)) begin
            failures++;
            $display("FAIL pxl_id k=%0d got=%0d exp=%0d", k, bus.disp_pxl_id_o, k / 4);
         end
         bus.pxl_en_i = 1'b1;
         @(negedge clk_i);
      end
      bus.pxl_en_i = 1'b0;
      checks++; if (bus.disp_pxl_id_o !== 8'd0) begin failures++; $display("FAIL pxl_wrap got=%0d exp=0", bus.disp_pxl_id_o); end
      bus.pxl_en_i = 1'b1;
      tick(5);
      bus.pxl_en_i = 1'b0;
      checks++; if (bus.disp_pxl_id_o !== 8'd1) begin failures++; $display("FAIL pxl_after5 got=%0d exp=1", bus.disp_pxl_id_o); end
      bus.pxl_en_i = 1'b1;
      bus.line_start_i = 1'b1;
      @(negedge clk_i);
      bus.line_start_i = 1'b0;
      checks++; if (bus.disp_pxl_id_o !== 8'd0) begin failures++; $display("FAIL pxl_ls_wins got=%0d exp=0", bus.disp_pxl_id_o); end
      tick(3);
      checks++; if (bus.disp_pxl_id_o !== 8'd0) begin failures++; $display("FAIL pxl_sub_clr got=%0d exp=0", bus.disp_pxl_id_o); end
      tick(1);
      bus.pxl_en_i = 1'b0;
      checks++; if (bus.disp_pxl_id_o !== 8'd1) begin failures++; $display("FAIL pxl_sub_step got=%0d exp=1", bus.disp_pxl_id_o); end
   endtask

   task automatic test_prime_and_swap();
      logic [1:0] r;
      logic [6:0] w;
      bit         s;
      int         base;
      do_reset();
      base = req_count;
      frame_pulse();
      checks++; if (bus.buff_fill_req_o !== 2'b00) begin failures++; $display("FAIL prime_entry_req got=%b exp=00", bus.buff_fill_req_o); end
      tick(1);
      checks++; if (bus.buff_fill_req_o !== 2'b01) begin failures++; $display("FAIL prime0_req got=%b exp=01", bus.buff_fill_req_o); end
      checks++; if (bus.fill_row_o !== 7'd0) begin failures++; $display("FAIL prime0_row got=%0d exp=0", bus.fill_row_o); end
      wait_req(300, r, w, s);
      checks++; if (!s) begin failures++; $display("FAIL prime1_timeout got=none exp=req"); end
      checks++; if (r !== 2'b10) begin failures++; $display("FAIL prime1_req got=%b exp=10", r); end
      checks++; if (w !== 7'd1) begin failures++; $display("FAIL prime1_row got=%0d exp=1", w); end
      tick(150);
      line_pulse();
      checks++; if (bus.buff_sel_o !== 2'b01) begin failures++; $display("FAIL line0_sel got=%b exp=01", bus.buff_sel_o); end
      tick(LINE_GAP - 1);
      for (int l = 1; l < 4; l++) begin
         line_pulse();
         tick(LINE_GAP - 1);
      end
      checks++; if (bus.buff_sel_o !== 2'b01) begin failures++; $display("FAIL line3_sel got=%b exp=01", bus.buff_sel_o); end
      line_pulse();
      checks++; if (bus.buff_sel_o !== 2'b10) begin failures++; $display("FAIL line4_sel got=%b exp=10", bus.buff_sel_o); end
      checks++; if (bus.buff_fill_req_o !== 2'b00) begin failures++; $display("FAIL swap_same_cycle_req got=%b exp=00", bus.buff_fill_req_o); end
      tick(1);
      checks++; if (bus.buff_fill_req_o !== 2'b01) begin failures++; $display("FAIL swap_req got=%b exp=01", bus.buff_fill_req_o); end
      checks++; if (bus.fill_row_o !== 7'd2) begin failures++; $display("FAIL swap_row got=%0d exp=2", bus.fill_row_o); end
      tick(2);
      checks++; if (bus.underrun_o !== 1'b0) begin failures++; $display("FAIL swap_underrun got=%b exp=0", bus.underrun_o); end
      checks++; if (req_count - base !== 3) begin failures++; $display("FAIL swap_req_count got=%0d exp=3", req_count - base); end
   endtask

   task automatic test_underrun();
      logic [1:0] r;
      logic [6:0] w;
      bit         s;
      int         base;
      do_reset();
      base = req_count;
      hold_done = 2'b10;
      frame_pulse();
      wait_req(300, r, w, s);
      wait_req(300, r, w, s);
      checks++; if (!s || r !== 2'b10) begin failures++; $display("FAIL ur_prime1 got=%b exp=10", r); end
      tick(150);
      for (int l = 0; l < 4; l++) begin
         line_pulse();
         tick(LINE_GAP - 1);
      end
      line_pulse();
      checks++; if (bus.buff_sel_o !== 2'b10) begin failures++; $display("FAIL ur_sel got=%b exp=10", bus.buff_sel_o); end
      checks++; if (bus.underrun_o !== 1'b1) begin failures++; $display("FAIL ur_flag got=%b exp=1", bus.underrun_o); end
      checks++; if (bus.underrun_cnt_o !== 8'(EXP_UCNT)) begin failures++; $display("FAIL ur_cnt got=%0d exp=%0d", bus.underrun_cnt_o, EXP_UCNT); end
      tick(20);
      checks++; if (req_count - base !== 2) begin failures++; $display("FAIL ur_deferred got=%0d exp=2", req_count - base); end
      hold_done = 2'b00;
      wait_req(50, r, w, s);
      checks++; if (!s) begin failures++; $display("FAIL ur_release_timeout got=none exp=req"); end
      checks++; if (r !== 2'b01 || w !== 7'd2) begin failures++; $display("FAIL ur_release_req got=%b/%0d exp=01/2", r, w); end
      tick(FILL_CYCLES + 20);
      frame_pulse();
      checks++; if (bus.underrun_o !== 1'b0) begin failures++; $display("FAIL ur_clear got=%b exp=0", bus.underrun_o); end
      checks++; if (bus.buff_sel_o !== 2'b00) begin failures++; $display("FAIL ur_fs_sel got=%b exp=00", bus.buff_sel_o); end
      checks++; if (bus.underrun_cnt_o !== 8'(EXP_UCNT)) begin failures++; $display("FAIL ur_cnt_keep got=%0d exp=%0d", bus.underrun_cnt_o, EXP_UCNT); end
   endtask

   task automatic test_full_frame();
      logic [1:0] exp_sel;
      int         base;
      do_reset();
      base = req_count;
      frame_pulse();
      tick(300);
      for (int l = 0; l < 480; l++) begin
         line_pulse();
         exp_sel = (((l / 4) % 2) == 0) ? 2'b01 : 2'b10;
         checks++;
         if (bus.buff_sel_o !== exp_sel) begin
            failures++;
            $display("FAIL frame_sel line=%0d got=%b exp=%b", l, bus.buff_sel_o, exp_sel);
         end
         tick(LINE_GAP - 1);
      end
      checks++; if (req_count - base !== 120) begin failures++; $display("FAIL frame_req_count got=%0d exp=120", req_count - base); end
      checks++; if (last_row !== 7'd119) begin failures++; $display("FAIL frame_last_row got=%0d exp=119", last_row); end
      checks++; if (bus.underrun_o !== 1'b0) begin failures++; $display("FAIL frame_underrun got=%b exp=0", bus.underrun_o); end
      line_pulse();
      checks++; if (bus.buff_sel_o !== 2'b00) begin failures++; $display("FAIL frame_end_sel got=%b exp=00", bus.buff_sel_o); end
      tick(200);
      checks++; if (req_count - base !== 120) begin failures++; $display("FAIL frame_idle_req got=%0d exp=120", req_count - base); end
      frame_pulse();
      tick(1);
      checks++; if (bus.buff_fill_req_o !== 2'b01 || bus.fill_row_o !== 7'd0) begin failures++; $display("FAIL frame_restart got=%b/%0d exp=01/0", bus.buff_fill_req_o, bus.fill_row_o); end
      checks++; if (proto_err !== 0) begin failures++; $display("FAIL protocol got=%0d exp=0", proto_err); end
   endtask

   task automatic test_abort();
      logic [1:0] r;
      logic [6:0] w;
      bit         s;
      int         base;
      do_reset();
      base = req_count;
      hold_done = 2'b10;
      frame_pulse();
      wait_req(300, r, w, s);
      wait_req(300, r, w, s);
      checks++; if (!s || r !== 2'b10) begin failures++; $display("FAIL abort_prime1 got=%b exp=10", r); end
      tick(20);
      line_pulse();
      checks++; if (bus.buff_sel_o !== 2'b01) begin failures++; $display("FAIL abort_pre_sel got=%b exp=01", bus.buff_sel_o); end
      tick(10);
      frame_pulse();
      checks++; if (bus.buff_sel_o !== 2'b00) begin failures++; $display("FAIL abort_sel got=%b exp=00", bus.buff_sel_o); end
      tick(200);
      checks++; if (req_count - base !== 2) begin failures++; $display("FAIL abort_drain got=%0d exp=2", req_count - base); end
      hold_done = 2'b00;
      wait_req(50, r, w, s);
      checks++; if (!s) begin failures++; $display("FAIL abort_release_timeout got=none exp=req"); end
      checks++; if (r !== 2'b01 || w !== 7'd0) begin failures++; $display("FAIL abort_reprime got=%b/%0d exp=01/0", r, w); end
      checks++; if (proto_err !== 0) begin failures++; $display("FAIL abort_protocol got=%0d exp=0", proto_err); end
   endtask

   task automatic test_reset_mid_fill();
      logic [1:0] r;
      logic [6:0] w;
      bit         s;
      int         base;
      do_reset();
      base = req_count;
      frame_pulse();
      wait_req(300, r, w, s);
      wait_req(300, r, w, s);
      checks++; if (!s || r !== 2'b10) begin failures++; $display("FAIL rmid_prime1 got=%b exp=10", r); end
      line_pulse();
      bus.pxl_en_i = 1'b1;
      tick(8);
      bus.pxl_en_i = 1'b0;
      checks++; if (bus.buff_sel_o !== 2'b01) begin failures++; $display("FAIL rmid_pre_sel got=%b exp=01", bus.buff_sel_o); end
      checks++; if (bus.disp_pxl_id_o !== 8'd2) begin failures++; $display("FAIL rmid_pre_id got=%0d exp=2", bus.disp_pxl_id_o); end
      checks++; if (bus.fill_row_o !== 7'd1) begin failures++; $display("FAIL rmid_pre_row got=%0d exp=1", bus.fill_row_o); end
      rst_i = 1'b1;
      #1;
      checks++; if (bus.buff_sel_o !== 2'b00) begin failures++; $display("FAIL rmid_sel got=%b exp=00", bus.buff_sel_o); end
      checks++; if (bus.disp_pxl_id_o !== 8'd0) begin failures++; $display("FAIL rmid_id got=%0d exp=0", bus.disp_pxl_id_o); end
      checks++; if (bus.fill_row_o !== 7'd0) begin failures++; $display("FAIL rmid_row got=%0d exp=0", bus.fill_row_o); end
      checks++; if (bus.buff_fill_req_o !== 2'b00) begin failures++; $display("FAIL rmid_req got=%b exp=00", bus.buff_fill_req_o); end
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      tick(300);
      checks++; if (req_count - base !== 2) begin failures++; $display("FAIL rmid_no_req got=%0d exp=2", req_count - base); end
      frame_pulse();
      tick(1);
      checks++; if (bus.buff_fill_req_o !== 2'b01 || bus.fill_row_o !== 7'd0) begin failures++; $display("FAIL rmid_restart got=%b/%0d exp=01/0", bus.buff_fill_req_o, bus.fill_row_o); end
   endtask

   initial begin
      bus.frame_start_i = 1'b0;
      bus.line_start_i  = 1'b0;
      bus.pxl_en_i      = 1'b0;
      test_reset();
      test_pixel_index();
      test_prime_and_swap();
      test_underrun();
      test_full_frame();
      test_abort();
      test_reset_mid_fill();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
